peak_freq_bcd: RTL

PEAK_FREQ_BCD -- requirements
Module: peak_freq_bcd

---
 rtl/peak_freq_pkg.sv | 18 +
 rtl/bcd_double_dabble.sv | 58 +++++
 rtl/peak_freq_bcd.sv | 126 ++++++++++++
 3 files changed

// File: rtl/peak_freq_pkg.sv
// Shared FSM encoding, default parameters and widths for the peak-bin to BCD
// frequency readout.
package peak_freq_pkg;

  localparam int NSAMPLES_DEF = 1024;
  localparam int FS_HZ_DEF    = 48000;
  localparam int KW           = $clog2(NSAMPLES_DEF);
  localparam int FW           = 16;
  localparam int BCDW         = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    CONV = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/bcd_double_dabble.sv
// Iterative 16-bit binary to 5-digit BCD converter, one shift-add-3 step per
// clock after a start pulse.
module bcd_double_dabble
  import peak_freq_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [FW-1:0]   bin,
  output logic            done,
  output logic [BCDW-1:0] bcd
);

  localparam int NDIG = BCDW / 4;
  localparam int CW   = $clog2(FW);
  localparam logic [CW-1:0] LAST = CW'(FW - 1);

  logic [FW-1:0]   bin_reg;
  logic [BCDW-1:0] bcd_reg;
  logic [BCDW-1:0] bcd_adj;
  logic [CW-1:0]   cnt_reg;
  logic            run_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_digit
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  bcd_reg[4*gi +: 4] + 4'd3 :
                                  bcd_reg[4*gi +: 4];
    end
  endgenerate

  // done marks the cycle whose clock edge commits the final step; bcd holds
  // the finished result from the following cycle on.
  assign done = run_reg && (cnt_reg == LAST);
  assign bcd  = bcd_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_reg <= '0;
      bcd_reg <= '0;
      cnt_reg <= '0;
      run_reg <= 1'b0;
    end else if (start) begin
      bin_reg <= bin;
      bcd_reg <= '0;
      cnt_reg <= '0;
      run_reg <= 1'b1;
    end else if (run_reg) begin
      {bcd_reg, bin_reg} <= {bcd_adj[BCDW-2:0], bin_reg, 1'b0};
      cnt_reg            <= cnt_reg + CW'(1);
      if (done) begin
        run_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/peak_freq_bcd.sv
// Converts an FFT peak bin index into a rounded frequency in Hz and its BCD
// digits, with a one-deep pending slot for indices arriving mid-conversion.
module peak_freq_bcd
  import peak_freq_pkg::*;
#(
  parameter int NSAMPLES = NSAMPLES_DEF,
  parameter int FS_HZ    = FS_HZ_DEF
)(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [$clog2(NSAMPLES)-1:0] peak_k,
  input  logic                        peak_valid,
  output logic [FW-1:0]               freq_hz,
  output logic [BCDW-1:0]             bcd,
  output logic                        bcd_valid,
  output logic                        busy,
  output logic                        overrun
);

  localparam int KWIDTH = $clog2(NSAMPLES);
  localparam int PW     = (KWIDTH + FW + 1 > 26) ? KWIDTH + FW + 1 : 26;

  localparam logic [KWIDTH:0]   N_FULL  = (KWIDTH + 1)'(NSAMPLES);
  localparam logic [KWIDTH-1:0] N_HALF  = KWIDTH'(NSAMPLES / 2);
  localparam logic [PW-1:0]     FS_P    = PW'(FS_HZ);
  localparam logic [PW-1:0]     ROUND_P = PW'(NSAMPLES / 2);

  state_t state_reg, state_next;

  logic [KWIDTH-1:0] k_reg;
  logic              pend_reg;
  logic [KWIDTH-1:0] pend_k_reg;
  logic [FW-1:0]     freq_reg;
  logic [FW-1:0]     freq_hz_reg;
  logic [BCDW-1:0]   bcd_reg;
  logic              bcd_valid_reg;

  logic [KWIDTH:0]   k_eff;
  logic [PW-1:0]     prod;
  logic [FW-1:0]     freq_calc;
  logic              dd_start;
  logic              dd_done;
  logic [BCDW-1:0]   dd_bcd;

  // Bins above Nyquist mirror back; the Nyquist bin itself folds onto N/2.
  assign k_eff     = (k_reg < N_HALF) ? {1'b0, k_reg} : N_FULL - {1'b0, k_reg};
  assign prod      = PW'(k_eff) * FS_P + ROUND_P;
  assign freq_calc = FW'(prod >> KWIDTH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    dd_start   = 1'b0;
    case (state_reg)
      IDLE: if (peak_valid) state_next = MULT;
      MULT: begin
        dd_start   = 1'b1;
        state_next = CONV;
      end
      CONV: if (dd_done) state_next = DONE;
      DONE: state_next = (peak_valid || pend_reg) ? MULT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_reg         <= '0;
      pend_reg      <= 1'b0;
      pend_k_reg    <= '0;
      freq_reg      <= '0;
      freq_hz_reg   <= '0;
      bcd_reg       <= '0;
      bcd_valid_reg <= 1'b0;
    end else begin
      bcd_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: if (peak_valid) k_reg <= peak_k;
        MULT, CONV: begin
          if (state_reg == MULT) freq_reg <= freq_calc;
          if (peak_valid) begin
            pend_reg   <= 1'b1;
            pend_k_reg <= peak_k;
          end
        end
        DONE: begin
          freq_hz_reg   <= freq_reg;
          bcd_reg       <= dd_bcd;
          bcd_valid_reg <= 1'b1;
          // A fresh strobe wins over the older pending index.
          if (peak_valid) begin
            k_reg <= peak_k;
          end else if (pend_reg) begin
            k_reg <= pend_k_reg;
          end
          pend_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // The converter loads the same value MULT registers, so CONV starts at step 0.
  bcd_double_dabble u_dd (
    .clk   (clk),
    .reset (reset),
    .start (dd_start),
    .bin   (freq_calc),
    .done  (dd_done),
    .bcd   (dd_bcd)
  );

  assign freq_hz   = freq_hz_reg;
  assign bcd       = bcd_reg;
  assign bcd_valid = bcd_valid_reg;
  assign busy      = (state_reg != IDLE);
  assign overrun   = peak_valid && pend_reg && (state_reg != IDLE);

endmodule
